// File: rtl/ones_acc_pkg.sv
// Shared definitions for the frame ones-count accumulator.
//   POP_W   : width of a per-byte ones count (0..8)
//   state_t : frame tracking state (IDLE = no open frame, ACCUM = frame open)
package ones_acc_pkg;

    localparam int unsigned POP_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/popcount8.sv
// Combinational ones counter for one byte.
//   i_data    : byte to count
//   o_count_c : number of set bits in i_data, 0..8 (combinational)
module popcount8
    import ones_acc_pkg::*;
(
    input  logic [7:0]       i_data,
    output logic [POP_W-1:0] o_count_c
);

    logic [POP_W-1:0] w_sum;

    // Sum the eight bits one at a time.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum + POP_W'(i_data[i]);
        end
    end

    assign o_count_c = w_sum;

endmodule

// File: rtl/ones_count_accumulator.sv
// Totals the set bits of each in_last-framed byte frame and presents one
// result per frame on a valid/ready output.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input beat handshake (in_ready is combinational)
//   in_data, in_last    : byte to count, final byte of the frame
//   out_valid/out_ready : result handshake
//   out_ones            : total set bits in the frame (saturating, CNT_W)
//   out_bytes           : bytes in the frame (saturating, LEN_W)
//   out_sat             : a counter clamped somewhere in the frame
module ones_count_accumulator
    import ones_acc_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_ones,
    output logic [LEN_W-1:0] out_bytes,
    output logic             out_sat
);

    state_t           r_state;
    logic [CNT_W-1:0] r_acc;
    logic [LEN_W-1:0] r_len;
    logic             r_sat;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_out_ones;
    logic [LEN_W-1:0] r_out_bytes;
    logic             r_out_sat;

    logic [POP_W-1:0] w_pop;
    logic             w_accept;
    logic             w_out_take;
    logic [CNT_W-1:0] w_acc_base;
    logic [LEN_W-1:0] w_len_base;
    logic [CNT_W:0]   w_acc_sum;
    logic [LEN_W:0]   w_len_sum;
    logic [CNT_W-1:0] w_acc_next;
    logic [LEN_W-1:0] w_len_next;
    logic             w_sat_next;

    popcount8 u_popcount8 (
        .i_data    (in_data),
        .o_count_c (w_pop)
    );

    // A pending result blocks input unless it is being taken this cycle.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_out_take = r_out_valid && out_ready;

    // A beat in IDLE starts a fresh frame, so the running totals count as zero.
    assign w_acc_base = (r_state == ACCUM) ? r_acc : '0;
    assign w_len_base = (r_state == ACCUM) ? r_len : '0;

    // Saturating adders: one extra bit catches the carry out, which clamps.
    assign w_acc_sum  = {1'b0, w_acc_base} + (CNT_W+1)'(w_pop);
    assign w_len_sum  = {1'b0, w_len_base} + (LEN_W+1)'(1'b1);
    assign w_acc_next = w_acc_sum[CNT_W] ? '1 : w_acc_sum[CNT_W-1:0];
    assign w_len_next = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];
    assign w_sat_next = ((r_state == ACCUM) && r_sat) || w_acc_sum[CNT_W] || w_len_sum[LEN_W];

    // Frame FSM, accumulators and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_len       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ones  <= '0;
            r_out_bytes <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_out_take) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (in_last) begin
                    // A last beat overrides a same-cycle handshake with the new result.
                    r_state     <= IDLE;
                    r_acc       <= '0;
                    r_len       <= '0;
                    r_sat       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_out_ones  <= w_acc_next;
                    r_out_bytes <= w_len_next;
                    r_out_sat   <= w_sat_next;
                end else begin
                    r_state <= ACCUM;
                    r_acc   <= w_acc_next;
                    r_len   <= w_len_next;
                    r_sat   <= w_sat_next;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ones  = r_out_ones;
    assign out_bytes = r_out_bytes;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Self-checking bench: two instances (default widths and CNT_W=4/LEN_W=3)
// share one stimulus stream; a frame-level model predicts both.
module tb_ones_count_accumulator;

    localparam int MAXC_A = 65535;
    localparam int MAXL_A = 4095;
    localparam int MAXC_B = 15;
    localparam int MAXL_B = 7;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_sat_a;
    logic [15:0] out_ones_a;
    logic [11:0] out_bytes_a;
    logic        in_ready_b, out_valid_b, out_sat_b;
    logic [3:0]  out_ones_b;
    logic [2:0]  out_bytes_b;

    int n_checks;
    int n_fail;
    bit run_cmp;

    ones_count_accumulator dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_ones(out_ones_a), .out_bytes(out_bytes_a), .out_sat(out_sat_a)
    );

    ones_count_accumulator #(.CNT_W(4), .LEN_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_ones(out_ones_b), .out_bytes(out_bytes_b), .out_sat(out_sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Frame-level model: an unbounded running total per frame, clamped once at
    // the end; a counter saturated iff the true total exceeds its maximum.
    bit m_valid;
    int m_fs, m_fl;
    int m_ones_a, m_bytes_a, m_ones_b, m_bytes_b;
    bit m_sat_a, m_sat_b;
    bit m_acc;
    int nx_fs, nx_fl;

    assign m_acc = in_valid && (!m_valid || out_ready);
    assign nx_fs = m_fs + $countones(in_data);
    assign nx_fl = m_fl + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_fs      <= 0;
            m_fl      <= 0;
            m_ones_a  <= 0;
            m_bytes_a <= 0;
            m_sat_a   <= 1'b0;
            m_ones_b  <= 0;
            m_bytes_b <= 0;
            m_sat_b   <= 1'b0;
        end else begin
            if (m_valid && out_ready) m_valid <= 1'b0;
            if (m_acc) begin
                if (in_last) begin
                    m_valid   <= 1'b1;
                    m_fs      <= 0;
                    m_fl      <= 0;
                    m_ones_a  <= clampi(nx_fs, MAXC_A);
                    m_bytes_a <= clampi(nx_fl, MAXL_A);
                    m_sat_a   <= (nx_fs > MAXC_A) || (nx_fl > MAXL_A);
                    m_ones_b  <= clampi(nx_fs, MAXC_B);
                    m_bytes_b <= clampi(nx_fl, MAXL_B);
                    m_sat_b   <= (nx_fs > MAXC_B) || (nx_fl > MAXL_B);
                end else begin
                    m_fs <= nx_fs;
                    m_fl <= nx_fl;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("in_ready_a", int'(in_ready_a), int'(!m_valid || out_ready));
            chk("in_ready_b", int'(in_ready_b), int'(!m_valid || out_ready));
            chk("out_valid_a", int'(out_valid_a), int'(m_valid));
            chk("out_valid_b", int'(out_valid_b), int'(m_valid));
            if (m_valid) begin
                chk("out_ones_a", int'(out_ones_a), m_ones_a);
                chk("out_bytes_a", int'(out_bytes_a), m_bytes_a);
                chk("out_sat_a", int'(out_sat_a), int'(m_sat_a));
                chk("out_ones_b", int'(out_ones_b), m_ones_b);
                chk("out_bytes_b", int'(out_bytes_b), m_bytes_b);
                chk("out_sat_b", int'(out_sat_b), int'(m_sat_b));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d, input logic last);
        int g;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        g = 0;
        while (!in_ready_a && g < 50) begin
            tick();
            g++;
        end
        if (g >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'hC3;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        run_cmp   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset state.
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_ones", int'(out_ones_a), 0);
        chk("rst_out_bytes", int'(out_bytes_a), 0);
        chk("rst_out_sat", int'(out_sat_a), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready_a), 1);
        run_cmp = 1'b1;
        tick();

        // Three-byte frame.
        send(8'hFF, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h01, 1'b1);
        chk("f3_valid", int'(out_valid_a), 1);
        chk("f3_ones", int'(out_ones_a), 13);
        chk("f3_bytes", int'(out_bytes_a), 3);
        chk("f3_sat", int'(out_sat_a), 0);

        // Single-byte frames back to back.
        send(8'hA5, 1'b1);
        chk("s1_ones", int'(out_ones_a), 4);
        chk("s1_bytes", int'(out_bytes_a), 1);
        send(8'h00, 1'b1);
        chk("s2_valid", int'(out_valid_a), 1);
        chk("s2_ones", int'(out_ones_a), 0);
        chk("s2_bytes", int'(out_bytes_a), 1);
        tick();

        // Backpressure hold, then release with a last beat on the same cycle.
        out_ready = 1'b0;
        send(8'h07, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", int'(in_ready_a), 0);
            chk("bp_ones_hold", int'(out_ones_a), 3);
            chk("bp_valid_hold", int'(out_valid_a), 1);
        end
        out_ready = 1'b1;
        send(8'h03, 1'b1);
        chk("bp_next_valid", int'(out_valid_a), 1);
        chk("bp_next_ones", int'(out_ones_a), 2);
        chk("bp_next_bytes", int'(out_bytes_a), 1);
        tick();

        // Saturation on the narrow instance.
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        chk("sat_ones_b", int'(out_ones_b), 15);
        chk("sat_bytes_b", int'(out_bytes_b), 3);
        chk("sat_flag_b", int'(out_sat_b), 1);
        chk("sat_ones_a", int'(out_ones_a), 24);
        chk("sat_flag_a", int'(out_sat_a), 0);
        send(8'h01, 1'b1);
        chk("sat_clear_b", int'(out_sat_b), 0);
        chk("sat_clear_ones_b", int'(out_ones_b), 1);
        for (int i = 0; i < 9; i++) send(8'h00, (i == 8) ? 1'b1 : 1'b0);
        chk("len_bytes_b", int'(out_bytes_b), 7);
        chk("len_sat_b", int'(out_sat_b), 1);
        chk("len_bytes_a", int'(out_bytes_a), 9);
        chk("len_sat_a", int'(out_sat_a), 0);
        tick();

        // Reset mid-clock discards a pending result.
        out_ready = 1'b0;
        send(8'h55, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", int'(out_valid_a), 0);
        chk("mrst_ones", int'(out_ones_a), 0);
        chk("mrst_sat", int'(out_sat_a), 0);
        tick();
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready", int'(in_ready_a), 1);
        tick();

        // Reset mid-frame discards the partial frame.
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h03, 1'b1);
        chk("pf_valid", int'(out_valid_a), 1);
        chk("pf_ones", int'(out_ones_a), 2);
        chk("pf_bytes", int'(out_bytes_a), 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
